// File: rtl/prog_loader_pkg.sv
// Shared types and widths for the program loader.
// Holds the FSM state encoding and the word/byte widths.
package prog_loader_pkg;

   localparam int WORD_W = 32;
   localparam int BYTE_W = 8;
   localparam int LEN_W  = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN0,
      S_LEN1,
      S_DATA,
      S_WRITE,
      S_DONE,
      S_ERR
   } state_t;

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Collects four stream bytes little-endian into one 32-bit word.
// Ports: clk, reset (async low), clear, load, byte_in -> word, word_full.
module word_assembler
   import prog_loader_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              load,
   input  logic [BYTE_W-1:0] byte_in,
   output logic [WORD_W-1:0] word,
   output logic              word_full
);

   logic [1:0] lane;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lane <= '0;
         word <= '0;
      end else if (clear) begin
         lane <= '0;
         word <= '0;
      end else if (load) begin
         word[{lane, 3'b000} +: BYTE_W] <= byte_in;
         lane <= lane + 2'd1;
      end
   end

   // High on the transfer that lands in the top lane.
   assign word_full = load && (lane == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader filling the core's instruction memory.
// Ports: clk, reset (async low), start, byte_in/byte_valid/byte_ready,
// instr_in/instr_in_addr/instr_we, core_hold, busy, done, err.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter logic [WORD_W-1:0] ADDR_BASE = 32'h0000_0000,
   parameter int unsigned       MAX_WORDS = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [BYTE_W-1:0] byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic [WORD_W-1:0] instr_in,
   output logic [WORD_W-1:0] instr_in_addr,
   output logic              instr_we,
   output logic              core_hold,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [WORD_W-1:0] MAX_W = MAX_WORDS;

   state_t             state_q, state_d;
   logic [BYTE_W-1:0]  len_lo;
   logic [LEN_W-1:0]   len_q, len_w;
   logic [LEN_W-1:0]   index, idx_inc;
   logic [WORD_W-1:0]  last_d, last_a;
   logic [WORD_W-1:0]  word, wr_addr;
   logic               word_full;
   logic               asm_clear, asm_load;

   assign len_w   = {byte_in, len_lo};
   assign idx_inc = index + 16'd1;
   // Byte offset of the word; the add wraps modulo 2^32.
   assign wr_addr = ADDR_BASE + {14'd0, index, 2'b00};

   word_assembler u_asm (
      .clk       (clk),
      .reset     (reset),
      .clear     (asm_clear),
      .load      (asm_load),
      .byte_in   (byte_in),
      .word      (word),
      .word_full (word_full)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      byte_ready = 1'b0;
      instr_we   = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      err        = 1'b0;
      core_hold  = 1'b1;
      asm_clear  = 1'b0;
      asm_load   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) state_d = S_LEN0;
         end
         S_LEN0: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
            if (byte_valid) state_d = S_LEN1;
         end
         S_LEN1: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
            if (byte_valid) begin
               asm_clear = 1'b1;
               if (len_w == '0)
                  state_d = S_DONE;
               else if ({16'd0, len_w} > MAX_W)
                  state_d = S_ERR;
               else
                  state_d = S_DATA;
            end
         end
         S_DATA: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
            asm_load   = byte_valid;
            if (word_full) state_d = S_WRITE;
         end
         S_WRITE: begin
            instr_we = 1'b1;
            busy     = 1'b1;
            if (idx_inc == len_q) state_d = S_DONE;
            else                  state_d = S_DATA;
         end
         S_DONE: begin
            done      = 1'b1;
            core_hold = 1'b0;
            if (start) state_d = S_LEN0;
         end
         S_ERR: begin
            err = 1'b1;
            if (start) state_d = S_LEN0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         len_lo <= '0;
         len_q  <= '0;
         index  <= '0;
         last_d <= '0;
         last_a <= ADDR_BASE;
      end else begin
         if (state_q == S_LEN0 && byte_valid)
            len_lo <= byte_in;
         if (state_q == S_LEN1 && byte_valid) begin
            len_q <= len_w;
            index <= '0;
         end
         if (state_q == S_WRITE) begin
            index  <= idx_inc;
            last_d <= word;
            last_a <= wr_addr;
         end
      end
   end

   // Write port shows the live word during WRITE, else the last write.
   assign instr_in      = (state_q == S_WRITE) ? word    : last_d;
   assign instr_in_addr = (state_q == S_WRITE) ? wr_addr : last_a;

endmodule
